// File: rtl/stack_ctrl.sv
// Two-register-headed LIFO with a spill array, sticky overflow/underflow flags.
// Define STACK_ERR_TRAP_EN to freeze the stack in a TRAP state on the first error.
module stack_ctrl #(
    parameter int unsigned SPILL_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                start,
    input  logic [2:0]                          op,
    input  logic [7:0]                          din_top,
    input  logic [7:0]                          din_pen,
    output logic [7:0]                          top_val,
    output logic [7:0]                          pen_val,
    output logic [$clog2(SPILL_DEPTH+3)-1:0]    depth,
    output logic                                full,
    output logic                                empty,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                trap
);

    localparam int unsigned CAP = SPILL_DEPTH + 2;
    localparam int unsigned DW  = $clog2(CAP + 1);
    localparam int unsigned SW  = (SPILL_DEPTH > 1) ? $clog2(SPILL_DEPTH) : 1;

    localparam logic [2:0] OpPush  = 3'b001;
    localparam logic [2:0] OpPop   = 3'b010;
    localparam logic [2:0] OpWr2   = 3'b011;
    localparam logic [2:0] OpPopWr = 3'b100;
    localparam logic [2:0] OpClear = 3'b101;

    logic [7:0]    top_q, top_d;
    logic [7:0]    pen_q, pen_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ovf_evt, unf_evt;
    logic          frozen;

    logic [7:0]    spill_q [SPILL_DEPTH];
    logic          spill_we;
    logic [SW-1:0] sp_wr;
    logic [SW-1:0] sp_rd;
    logic [7:0]    spill_rd;

`ifdef STACK_ERR_TRAP_EN
    typedef enum logic {StRun, StTrap} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (ovf_evt || unf_evt) state_d = StTrap;
            StTrap:  state_d = StTrap;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        trap   = (state_q == StTrap);
        frozen = (state_q == StTrap);
    end
`else
    assign trap   = 1'b0;
    assign frozen = 1'b0;
`endif

    // sp = depth-2 is the next free spill slot; depth-3 is the slot feeding pen on a pop.
    always_comb begin
        sp_wr    = SW'(depth_q - DW'(2));
        sp_rd    = SW'(depth_q - DW'(3));
        spill_rd = (depth_q >= DW'(3)) ? spill_q[sp_rd] : 8'h00;
    end

    always_comb begin
        top_d    = top_q;
        pen_d    = pen_q;
        depth_d  = depth_q;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        spill_we = 1'b0;
        if (!frozen) begin
            case (op)
                OpPush: begin
                    if (depth_q == DW'(CAP)) begin
                        ovf_evt = 1'b1;
                    end else begin
                        pen_d    = top_q;
                        top_d    = din_top;
                        depth_d  = depth_q + DW'(1);
                        spill_we = (depth_q >= DW'(2));
                    end
                end
                OpPop: begin
                    if (depth_q == '0) begin
                        unf_evt = 1'b1;
                    end else begin
                        top_d   = pen_q;
                        pen_d   = spill_rd;
                        depth_d = depth_q - DW'(1);
                    end
                end
                OpWr2: begin
                    if (depth_q < DW'(2)) begin
                        unf_evt = 1'b1;
                    end else begin
                        top_d = din_top;
                        pen_d = din_pen;
                    end
                end
                OpPopWr: begin
                    if (depth_q < DW'(2)) begin
                        unf_evt = 1'b1;
                    end else begin
                        top_d   = din_top;
                        pen_d   = spill_rd;
                        depth_d = depth_q - DW'(1);
                    end
                end
                OpClear: begin
                    top_d   = 8'h00;
                    pen_d   = 8'h00;
                    depth_d = '0;
                end
                default: ;
            endcase
        end
        ovf_d = ovf_q | ovf_evt;
        unf_d = unf_q | unf_evt;
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            top_q   <= 8'h00;
            pen_q   <= 8'h00;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            pen_q   <= pen_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Spill contents are never observable past sp, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (spill_we) begin
            spill_q[sp_wr] <= pen_q;
        end
    end

    always_comb begin
        top_val   = top_q;
        pen_val   = pen_q;
        depth     = depth_q;
        full      = (depth_q == DW'(CAP));
        empty     = (depth_q == '0);
        overflow  = ovf_q;
        underflow = unf_q;
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl (default SPILL_DEPTH, CAP = 18).
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       start = 1'b1;
    logic [2:0] op = 3'b000;
    logic [7:0] din_top = 8'h00;
    logic [7:0] din_pen = 8'h00;
    logic [7:0] top_val, pen_val;
    logic [4:0] depth;
    logic       full, empty, overflow, underflow, trap;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, WR2 = 3'b011;
    localparam logic [2:0] POPWR = 3'b100, CLEAR = 3'b101;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk       (clk),
        .start     (start),
        .op        (op),
        .din_top   (din_top),
        .din_pen   (din_pen),
        .top_val   (top_val),
        .pen_val   (pen_val),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .trap      (trap)
    );

    task automatic do_op(input logic [2:0] o, input logic [7:0] t, input logic [7:0] p);
        @(negedge clk);
        op = o; din_top = t; din_pen = p;
        @(posedge clk);
        #1;
        op = NOP;
    endtask

    task automatic do_reset();
        @(negedge clk);
        op = NOP;
        start = 1'b1;
        #2;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
        checks++; if (top_val !== 8'h00) begin errors++; $display("FAIL reset_top got %h exp 00", top_val); end
        checks++; if (pen_val !== 8'h00) begin errors++; $display("FAIL reset_pen got %h exp 00", pen_val); end
        checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty got %b exp 01", {full, empty}); end
        checks++; if ({overflow, underflow, trap} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {overflow, underflow, trap}); end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_push_two();
        do_reset();
        do_op(PUSH, 8'h11, 8'h00);
        do_op(PUSH, 8'h22, 8'h00);
        checks++; if (top_val !== 8'h22) begin errors++; $display("FAIL push2_top got %h exp 22", top_val); end
        checks++; if (pen_val !== 8'h11) begin errors++; $display("FAIL push2_pen got %h exp 11", pen_val); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL push2_depth got %0d exp 2", depth); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push2_empty got %b exp 0", empty); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 18; i++) do_op(PUSH, 8'(i), 8'h00);
        checks++; if (depth !== 5'd18) begin errors++; $display("FAIL fill_depth got %0d exp 18", depth); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", overflow); end
        do_op(PUSH, 8'hFF, 8'h00);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (depth !== 5'd18) begin errors++; $display("FAIL ovf_depth got %0d exp 18", depth); end
        checks++; if (top_val !== 8'h12) begin errors++; $display("FAIL ovf_top got %h exp 12", top_val); end
        checks++; if (pen_val !== 8'h11) begin errors++; $display("FAIL ovf_pen got %h exp 11", pen_val); end
`ifdef STACK_ERR_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL ovf_trap got %b exp 1", trap); end
        do_reset();
        for (int i = 1; i <= 18; i++) do_op(PUSH, 8'(i), 8'h00);
`endif
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (top_val !== 8'(18 - k)) begin
                errors++; $display("FAIL drain_top[%0d] got %h exp %h", k, top_val, 8'(18 - k));
            end
            do_op(POP, 8'h00, 8'h00);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL drain_depth got %0d exp 0", depth); end
        checks++; if ({top_val, pen_val} !== 16'h0000) begin errors++; $display("FAIL drain_vals got %h exp 0000", {top_val, pen_val}); end
    endtask

    task automatic test_popwr_wr2();
        do_reset();
        do_op(PUSH, 8'h07, 8'h00);
        do_op(PUSH, 8'h03, 8'h00);
        do_op(PUSH, 8'h05, 8'h00);
        do_op(POPWR, 8'h08, 8'h00);
        checks++; if (top_val !== 8'h08) begin errors++; $display("FAIL popwr_top got %h exp 08", top_val); end
        checks++; if (pen_val !== 8'h07) begin errors++; $display("FAIL popwr_pen got %h exp 07", pen_val); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL popwr_depth got %0d exp 2", depth); end
        do_op(WR2, 8'h5A, 8'hA5);
        checks++; if ({top_val, pen_val} !== 16'h5AA5) begin errors++; $display("FAIL wr2_vals got %h exp 5AA5", {top_val, pen_val}); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL wr2_depth got %0d exp 2", depth); end
        do_op(POPWR, 8'h09, 8'h00);
        checks++; if ({top_val, pen_val} !== 16'h0900) begin errors++; $display("FAIL popwr2_vals got %h exp 0900", {top_val, pen_val}); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL popwr2_depth got %0d exp 1", depth); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL popwr2_unf got %b exp 0", underflow); end
        do_op(WR2, 8'h44, 8'h55);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL wr2_unf got %b exp 1", underflow); end
        checks++; if ({top_val, pen_val} !== 16'h0900) begin errors++; $display("FAIL wr2_unf_vals got %h exp 0900", {top_val, pen_val}); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL wr2_unf_depth got %0d exp 1", depth); end
`ifdef STACK_ERR_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL wr2_trap got %b exp 1", trap); end
`endif
    endtask

    task automatic test_underflow();
        do_reset();
        do_op(POP, 8'h00, 8'h00);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL pop_empty_unf got %b exp 1", underflow); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL pop_empty_depth got %0d exp 0", depth); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop_empty_ovf got %b exp 0", overflow); end
        do_op(PUSH, 8'hAA, 8'h00);
`ifdef STACK_ERR_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL unf_trap got %b exp 1", trap); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL trap_depth got %0d exp 0", depth); end
        checks++; if (top_val !== 8'h00) begin errors++; $display("FAIL trap_top got %h exp 00", top_val); end
`else
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL notrap got %b exp 0", trap); end
        checks++; if (top_val !== 8'hAA) begin errors++; $display("FAIL after_unf_top got %h exp AA", top_val); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL after_unf_depth got %0d exp 1", depth); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b exp 1", underflow); end
`endif
    endtask

    task automatic test_clear_nop();
        do_reset();
        do_op(PUSH, 8'h3C, 8'h00);
        do_op(PUSH, 8'h4D, 8'h00);
        do_op(3'b110, 8'hEE, 8'hEE);
        do_op(3'b111, 8'hEE, 8'hEE);
        checks++; if ({top_val, pen_val} !== 16'h4D3C) begin errors++; $display("FAIL nop_vals got %h exp 4D3C", {top_val, pen_val}); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL nop_depth got %0d exp 2", depth); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL nop_flags got %b exp 00", {overflow, underflow}); end
        do_op(CLEAR, 8'h00, 8'h00);
        checks++; if ({top_val, pen_val} !== 16'h0000) begin errors++; $display("FAIL clear_vals got %h exp 0000", {top_val, pen_val}); end
        checks++; if ({depth, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL clear_depth got %0d/%b exp 0/1", depth, empty); end
        do_op(PUSH, 8'h77, 8'h00);
        checks++; if ({top_val, pen_val} !== 16'h7700) begin errors++; $display("FAIL post_clear got %h exp 7700", {top_val, pen_val}); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL post_clear_depth got %0d exp 1", depth); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) do_op(PUSH, 8'(i), 8'h00);
        @(negedge clk);
        op = PUSH; din_top = 8'h99;
        @(posedge clk);
        #2;
        checks++; if (depth !== 5'd4) begin errors++; $display("FAIL stream_depth got %0d exp 4", depth); end
        start = 1'b1;
        #1;
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL async_depth got %0d exp 0", depth); end
        checks++; if ({top_val, pen_val} !== 16'h0000) begin errors++; $display("FAIL async_vals got %h exp 0000", {top_val, pen_val}); end
        checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL async_full_empty got %b exp 01", {full, empty}); end
        op = NOP;
        @(negedge clk);
        start = 1'b0;
        do_op(PUSH, 8'hAB, 8'h00);
        checks++; if ({top_val, pen_val} !== 16'hAB00) begin errors++; $display("FAIL first_op got %h exp AB00", {top_val, pen_val}); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL first_op_depth got %0d exp 1", depth); end
    endtask

    initial begin
        test_reset();
        test_push_two();
        test_fill_drain();
        test_popwr_wr2();
        test_underflow();
        test_clear_nop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
